// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) sharing one memory port.
// Optional macro ILLEGAL_TRAP_EN: opcode 7 traps into a sticky TRAP state with illegal_op.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ALU_OP       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_sel,
  output logic                    irWrite,
  output logic                    pcWrite,
  output logic                    branch,
  output logic                    regWrite,
  output logic                    regDest,
  output logic                    ALUsrc,
  output logic [ALU_OP-1:0]       ALUControl,
  output logic                    MemToReg,
  output logic                    retire,
`ifdef ILLEGAL_TRAP_EN
  output logic                    illegal_op,
`endif
  output logic [2:0]              state_o
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNQ   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(6);

  localparam logic [ALU_OP-1:0] ALU_ADD = ALU_OP'(0);
  localparam logic [ALU_OP-1:0] ALU_SUB = ALU_OP'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
`ifdef ILLEGAL_TRAP_EN
    , TRAP = 3'd6
`endif
  } state_t;

  state_t                  state, next_state, boundary;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic                    alu_src_dec;
  logic [ALU_OP-1:0]       alu_ctl_dec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && mem_ready) op_q <= opcode;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  illegal_op <= 1'b0;
    else if (state == EXEC && op_q == '1)        illegal_op <= 1'b1;
  end
`endif

  // Operand-B and ALU function per opcode; reused in EXEC and WB.
  always_comb begin
    alu_src_dec = (op_q == OP_ADDI) || (op_q == OP_SUBI) ||
                  (op_q == OP_LOAD) || (op_q == OP_STORE);
    alu_ctl_dec = ((op_q == OP_SUB) || (op_q == OP_SUBI) || (op_q == OP_BNQ))
                  ? ALU_SUB : ALU_ADD;
  end

  assign boundary = run ? FETCH : IDLE;
  assign state_o  = state;

  // NOTE: every output and next_state gets a default first so no path through
  // the case statement leaves a value unassigned (which would infer a latch).
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    regWrite   = 1'b0;
    regDest    = 1'b0;
    ALUsrc     = 1'b0;
    ALUControl = ALU_ADD;
    MemToReg   = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: if (run) next_state = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        ALUsrc     = alu_src_dec;
        ALUControl = alu_ctl_dec;
        case (op_q)
          OP_BNQ: begin
            branch     = 1'b1;
            retire     = 1'b1;
            next_state = boundary;
          end
          OP_LOAD, OP_STORE:               next_state = MEM;
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: next_state = WB;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            next_state = TRAP;
`else
            retire     = 1'b1;
            next_state = boundary;
`endif
          end
        endcase
      end
      MEM: begin
        // Address path and write select stay frozen while the request waits.
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op_q == OP_STORE);
        ALUsrc  = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            retire     = 1'b1;
            next_state = boundary;
          end else begin
            next_state = WB;
          end
        end
      end
      WB: begin
        regWrite   = 1'b1;
        regDest    = (op_q == OP_ADD) || (op_q == OP_SUB);
        MemToReg   = (op_q == OP_LOAD);
        ALUsrc     = alu_src_dec;
        ALUControl = alu_ctl_dec;
        retire     = 1'b1;
        next_state = boundary;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: next_state = TRAP;
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; each cycle compares the full output word
// {mem_req,mem_we,mem_sel,irWrite,pcWrite,branch,regWrite,regDest,ALUsrc,ALUControl,MemToReg,retire,state_o}.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, irWrite, pcWrite, branch;
  logic       regWrite, regDest, ALUsrc, MemToReg, retire;
  logic [2:0] ALUControl, state_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int vectors = 0;
  int errors  = 0;

  // Output-word field constants; low 3 bits are the state code.
  localparam logic [16:0] MREQ = 17'h10000;
  localparam logic [16:0] MWE  = 17'h08000;
  localparam logic [16:0] MSEL = 17'h04000;
  localparam logic [16:0] IRW  = 17'h02000;
  localparam logic [16:0] PCW  = 17'h01000;
  localparam logic [16:0] BR   = 17'h00800;
  localparam logic [16:0] RW   = 17'h00400;
  localparam logic [16:0] RD   = 17'h00200;
  localparam logic [16:0] ASRC = 17'h00100;
  localparam logic [16:0] SUBC = 17'h00020;
  localparam logic [16:0] M2R  = 17'h00010;
  localparam logic [16:0] RET  = 17'h00008;

  multicycle_control #(.OPCODE_WIDTH(3), .ALU_OP(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .irWrite(irWrite),
    .pcWrite(pcWrite), .branch(branch), .regWrite(regWrite), .regDest(regDest),
    .ALUsrc(ALUsrc), .ALUControl(ALUControl), .MemToReg(MemToReg), .retire(retire),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {mem_req, mem_we, mem_sel, irWrite, pcWrite, branch, regWrite, regDest,
            ALUsrc, ALUControl, MemToReg, retire, state_o};
  endfunction

  // Drive one cycle's inputs {run, opcode, mem_ready} mid-cycle and sample outputs.
  task automatic step(input logic [4:0] stim, output logic [16:0] obs);
    @(negedge clk);
    {run, opcode, mem_ready} = stim;
    #1;
    obs = outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; opcode = 3'd0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    logic [4:0]  stim [5] = '{5'b1_000_0, 5'b1_011_1, 5'b1_011_0, 5'b1_011_0, 5'b1_011_0};
    logic [16:0] exp  [5] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, ASRC|17'd3, MREQ|MWE|MSEL|ASRC|17'd4};
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== 17'd0) begin errors++; $display("FAIL reset_hold got=%h exp=%h", outs(), 17'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL reset_store cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== 17'd0) begin errors++; $display("FAIL reset_async got=%h exp=%h", outs(), 17'd0); end
    @(posedge clk); #1;
    vectors++;
    if (outs() !== 17'd0) begin errors++; $display("FAIL reset_after_edge got=%h exp=%h", outs(), 17'd0); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
  endtask

  task automatic test_add();
    logic [16:0] obs;
    logic [4:0]  stim [6] = '{5'b1_000_0, 5'b1_000_1, 5'b1_000_0, 5'b1_000_0, 5'b1_000_0, 5'b1_000_0};
    logic [16:0] exp  [6] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, 17'd3, RW|RD|RET|17'd5, MREQ|17'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] obs;
    logic [4:0]  stim [9] = '{5'b1_010_0, 5'b1_010_1, 5'b1_010_0, 5'b1_010_0, 5'b1_010_0,
                             5'b1_010_0, 5'b1_010_1, 5'b0_010_0, 5'b0_010_0};
    logic [16:0] exp  [9] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, ASRC|17'd3,
                             MREQ|MSEL|ASRC|17'd4, MREQ|MSEL|ASRC|17'd4, MREQ|MSEL|ASRC|17'd4,
                             RW|ASRC|M2R|RET|17'd5, 17'd0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL load cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_store();
    logic [16:0] obs;
    logic [4:0]  stim [7] = '{5'b1_011_0, 5'b1_011_1, 5'b1_011_0, 5'b1_011_0, 5'b1_011_0,
                             5'b0_011_1, 5'b0_011_0};
    logic [16:0] exp  [7] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, ASRC|17'd3,
                             MREQ|MWE|MSEL|ASRC|17'd4, MREQ|MWE|MSEL|ASRC|RET|17'd4, 17'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL store cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

  // mem_ready held high in DECODE/EXEC must be ignored.
  task automatic test_bnq();
    logic [16:0] obs;
    logic [4:0]  stim [6] = '{5'b1_100_0, 5'b1_100_0, 5'b1_100_1, 5'b1_100_1, 5'b0_100_1, 5'b0_100_1};
    logic [16:0] exp  [6] = '{17'd0, MREQ|17'd1, MREQ|IRW|PCW|17'd1, 17'd2, BR|SUBC|RET|17'd3, 17'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL bnq cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_run_drop();
    logic [16:0] obs;
    logic [4:0]  stim [8] = '{5'b1_101_0, 5'b1_101_1, 5'b0_101_0, 5'b0_101_0, 5'b0_101_0,
                             5'b0_101_0, 5'b1_101_0, 5'b1_101_0};
    logic [16:0] exp  [8] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, ASRC|SUBC|17'd3,
                             RW|ASRC|SUBC|RET|17'd5, 17'd0, 17'd0, MREQ|17'd1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL run_drop cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

  // SUB immediately followed by ADDI with run held high.
  task automatic test_back_to_back();
    logic [16:0] obs;
    logic [4:0]  stim [10] = '{5'b1_110_0, 5'b1_110_1, 5'b1_110_0, 5'b1_110_0, 5'b1_110_0,
                              5'b1_001_1, 5'b1_001_0, 5'b1_001_0, 5'b0_001_0, 5'b0_001_0};
    logic [16:0] exp  [10] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, SUBC|17'd3, RW|RD|SUBC|RET|17'd5,
                              MREQ|IRW|PCW|17'd1, 17'd2, ASRC|17'd3, RW|ASRC|RET|17'd5, 17'd0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask

`ifdef ILLEGAL_TRAP_EN
  task automatic test_op7();
    logic [16:0] obs;
    logic [4:0]  stim [6] = '{5'b1_111_0, 5'b1_111_1, 5'b1_111_0, 5'b1_111_0, 5'b1_111_1, 5'b0_111_1};
    logic [16:0] exp  [6] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, 17'd3, 17'd6, 17'd6};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL trap cyc%0d got=%h exp=%h", i, obs, exp[i]); end
      vectors++;
      if (illegal_op !== (i >= 4)) begin errors++; $display("FAIL illegal_op cyc%0d got=%b exp=%b", i, illegal_op, (i >= 4)); end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({illegal_op, state_o} !== 4'd0) begin errors++; $display("FAIL trap_reset got=%h exp=0", {illegal_op, state_o}); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
  endtask
`else
  task automatic test_op7();
    logic [16:0] obs;
    logic [4:0]  stim [5] = '{5'b1_111_0, 5'b1_111_1, 5'b1_111_0, 5'b0_111_0, 5'b0_111_0};
    logic [16:0] exp  [5] = '{17'd0, MREQ|IRW|PCW|17'd1, 17'd2, RET|17'd3, 17'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(stim[i], obs);
      vectors++;
      if (obs !== exp[i]) begin errors++; $display("FAIL nop cyc%0d got=%h exp=%h", i, obs, exp[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_bnq();
    test_run_drop();
    test_back_to_back();
    test_op7();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
